// File: rtl/baud_tick_gen_pkg.sv
// baud_tick_gen_pkg
//   Shared UART timing constants and the small types used by the baud
//   tick generator. TX and RX import the same constants so they always
//   agree on oversample ratio and default divisor.
//   UART_DEFAULT_DIV = CLK_HZ / (BAUD * OSR), truncated (12 MHz -> 78).
`timescale 1ns/1ps
package baud_tick_gen_pkg;

  localparam int UART_CLK_HZ      = 12_000_000;
  localparam int UART_BAUD        = 9600;
  localparam int UART_OSR         = 16;
  localparam int UART_DIV_W       = 16;
  localparam int UART_DEFAULT_DIV = UART_CLK_HZ / (UART_BAUD * UART_OSR);

  // What the phase/tick stage does on a given edge, already resolved by priority.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_COUNT = 2'd1,
    ACT_CLEAR = 2'd2
  } count_act_e;

endpackage

// File: rtl/baud_tick_gen_if.sv
// baud_tick_gen_if
//   Control and strobe bundle of the baud tick generator.
//   master : the consumer side (drives enable/divisor/resync, reads strobes)
//   slave  : the generator itself
//   Signals:
//     i_en        count enable
//     i_div       new divisor (clock cycles per oversample tick)
//     i_div_load  one-cycle pulse, latch i_div
//     i_resync    one-cycle pulse, restart prescaler and phase
//     o_os_tick   oversample strobe
//     o_bit_tick  bit strobe (phase wraps OSR-1 -> 0)
//     o_mid_tick  mid-bit strobe (phase becomes OSR/2)
//     o_phase     current oversample phase
//     o_baud_clk  bit-rate square wave
`timescale 1ns/1ps
interface baud_tick_gen_if
  import baud_tick_gen_pkg::*;
#(
  parameter int DIV_W = UART_DIV_W,
  parameter int OSR   = UART_OSR
);

  localparam int PHASE_W = $clog2(OSR);

  logic               i_en;
  logic [DIV_W-1:0]   i_div;
  logic               i_div_load;
  logic               i_resync;
  logic               o_os_tick;
  logic               o_bit_tick;
  logic               o_mid_tick;
  logic [PHASE_W-1:0] o_phase;
  logic               o_baud_clk;

  modport master (
    output i_en, i_div, i_div_load, i_resync,
    input  o_os_tick, o_bit_tick, o_mid_tick, o_phase, o_baud_clk
  );

  modport slave (
    input  i_en, i_div, i_div_load, i_resync,
    output o_os_tick, o_bit_tick, o_mid_tick, o_phase, o_baud_clk
  );

endinterface

// File: rtl/baud_tick_gen_tick_prescaler.sv
// tick_prescaler
//   Free-running 0..i_div-1 counter used as the oversample prescaler.
//   Ports:
//     i_clk, i_rst_n  clock, async active-low reset
//     i_en            count enable (low = hold count)
//     i_clr           synchronous clear to 0 (wins over i_en)
//     i_div           period in clock cycles, expected >= 2
//     o_tick          high in the cycle whose edge wraps the counter
//   o_tick is a decode of the current count, not a register: the parent
//   registers it together with the phase so that the os/bit/mid strobes
//   and the phase value all change on the same edge.
`timescale 1ns/1ps
module tick_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] count;
  logic             at_end;

  // >= rather than == so a count can never run past the terminal value.
  assign at_end = (count >= (i_div - 1'b1));
  assign o_tick = i_en && !i_clr && at_end;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_clr) begin
      count <= '0;
    end else if (i_en) begin
      count <= at_end ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen
//   Baud-rate strobe generator for the UART datapath. Produces single-cycle
//   strobes on i_clk instead of a derived clock.
//   Parameters:
//     DIV_W        divisor / prescaler width
//     OSR          oversample ratio, power of two, >= 4
//     DEFAULT_DIV  divisor after reset
//   Ports:
//     i_clk, i_rst_n  system clock, async active-low reset
//     bus             baud_tick_gen_if.slave (enable, divisor load, resync,
//                     os/bit/mid strobes, phase, baud square wave)
//   All outputs are registers; nothing on the bus passes combinationally
//   from an input to an output.
`timescale 1ns/1ps
module baud_tick_gen
  import baud_tick_gen_pkg::*;
#(
  parameter int DIV_W       = UART_DIV_W,
  parameter int OSR         = UART_OSR,
  parameter int DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  baud_tick_gen_if.slave bus
);

  localparam int PHASE_W = $clog2(OSR);
  localparam logic [PHASE_W-1:0] PHASE_LAST    = PHASE_W'(OSR - 1);
  localparam logic [PHASE_W-1:0] PHASE_PRE_MID = PHASE_W'(OSR / 2 - 1);
  localparam logic [DIV_W-1:0]   DIV_MIN       = DIV_W'(2);
  localparam logic [DIV_W-1:0]   DIV_RESET     = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0]   div_reg;
  logic               clr;
  logic               wrap;
  count_act_e         act;
  logic [PHASE_W-1:0] phase_q;
  logic               os_tick_q;
  logic               bit_tick_q;
  logic               mid_tick_q;
  logic               baud_clk_q;

  // A load or a resync both restart the prescaler and phase from zero.
  assign clr = bus.i_div_load | bus.i_resync;

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (bus.i_en),
    .i_clr   (clr),
    .i_div   (div_reg),
    .o_tick  (wrap)
  );

  // Divisors below 2 are clamped so the strobe is never stuck and never
  // fires every cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_reg <= DIV_RESET;
    end else if (bus.i_div_load) begin
      div_reg <= (bus.i_div < DIV_MIN) ? DIV_MIN : bus.i_div;
    end
  end

  always_comb begin
    act = ACT_HOLD;
    if (clr) begin
      act = ACT_CLEAR;
    end else if (wrap) begin
      act = ACT_COUNT;
    end
  end

  // Phase wraps for free because OSR is a power of two. bit/mid decode the
  // phase value being left, so the strobe lines up with the new phase.
  // baud_clk holds through clears and enable gaps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q    <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
      baud_clk_q <= 1'b0;
    end else begin
      case (act)
        ACT_CLEAR: begin
          phase_q    <= '0;
          os_tick_q  <= 1'b0;
          bit_tick_q <= 1'b0;
          mid_tick_q <= 1'b0;
        end
        ACT_COUNT: begin
          phase_q    <= phase_q + 1'b1;
          os_tick_q  <= 1'b1;
          bit_tick_q <= (phase_q == PHASE_LAST);
          mid_tick_q <= (phase_q == PHASE_PRE_MID);
          if (phase_q == PHASE_LAST) begin
            baud_clk_q <= 1'b1;
          end else if (phase_q == PHASE_PRE_MID) begin
            baud_clk_q <= 1'b0;
          end
        end
        default: begin
          os_tick_q  <= 1'b0;
          bit_tick_q <= 1'b0;
          mid_tick_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_os_tick  = os_tick_q;
  assign bus.o_bit_tick = bit_tick_q;
  assign bus.o_mid_tick = mid_tick_q;
  assign bus.o_phase    = phase_q;
  assign bus.o_baud_clk = baud_clk_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen
//   Scoreboard bench for baud_tick_gen. The reference model tracks the
//   number of enabled cycles since the last clear (n) and the active
//   divisor (d); os tick when n is a multiple of d, phase = (n/d) mod OSR.
//   Each clock edge pushes the expected outputs; a monitor pops and
//   compares on the falling edge.
`timescale 1ns/1ps
module tb_baud_tick_gen;

  localparam int DIV_W   = 16;
  localparam int OSR     = 16;
  localparam int PHASE_W = 4;
  localparam int DEF_DIV = 78;

  typedef struct packed {
    logic               os;
    logic               bt;
    logic               mid;
    logic [PHASE_W-1:0] phase;
    logic               bclk;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  int   n      = 0;
  int   d      = DEF_DIV;
  logic m_bclk = 1'b0;

  always #5 clk = ~clk;

  baud_tick_gen_if #(.DIV_W(DIV_W), .OSR(OSR)) bif ();

  baud_tick_gen #(
    .DIV_W       (DIV_W),
    .OSR         (OSR),
    .DEFAULT_DIV (DEF_DIV)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bif)
  );

  function automatic int model_phase();
    return (n / d) % OSR;
  endfunction

  // Advance the reference model by one clock edge and queue its outputs.
  task automatic model_edge();
    exp_t e;
    int   k;
    e = '0;
    if (!rst_n) begin
      d      = DEF_DIV;
      n      = 0;
      m_bclk = 1'b0;
    end else if (bif.i_div_load) begin
      d = (int'(bif.i_div) < 2) ? 2 : int'(bif.i_div);
      n = 0;
    end else if (bif.i_resync) begin
      n = 0;
    end else if (bif.i_en) begin
      n++;
      if ((n % d) == 0) begin
        e.os = 1'b1;
        k = (n / d) % OSR;
        if (k == 0) begin
          e.bt   = 1'b1;
          m_bclk = 1'b1;
        end
        if (k == OSR / 2) begin
          e.mid  = 1'b1;
          m_bclk = 1'b0;
        end
      end
    end
    e.phase = PHASE_W'(model_phase());
    e.bclk  = m_bclk;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic en, input logic load,
                               input logic [DIV_W-1:0] div, input logic resync);
    bif.i_en       = en;
    bif.i_div_load = load;
    bif.i_div      = div;
    bif.i_resync   = resync;
    @(posedge clk);
    model_edge();
    #1;
    bif.i_div_load = 1'b0;
    bif.i_resync   = 1'b0;
  endtask

  task automatic run_cycles(input int cycles, input logic en);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(en, 1'b0, bif.i_div, 1'b0);
    end
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    exp_t a;
    a.os    = bif.o_os_tick;
    a.bt    = bif.o_bit_tick;
    a.mid   = bif.o_mid_tick;
    a.phase = bif.o_phase;
    a.bclk  = bif.o_baud_clk;
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("[TB] FAIL %s @%0t: got os=%b bit=%b mid=%b phase=%0d bclk=%b, expected os=%b bit=%b mid=%b phase=%0d bclk=%b",
               name, $time, a.os, a.bt, a.mid, a.phase, a.bclk,
               e.os, e.bt, e.mid, e.phase, e.bclk);
    end
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("scoreboard", e);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    int   guard;
    exp_t zero;
    zero = '0;

    bif.i_en       = 1'b1;
    bif.i_div      = '0;
    bif.i_div_load = 1'b0;
    bif.i_resync   = 1'b0;

    // Reset defaults: three edges in reset, then free run at divisor 78.
    run_cycles(3, 1'b1);
    rst_n = 1'b1;
    run_cycles(2 * DEF_DIV * OSR + 100, 1'b1);

    // Divisor load of 5.
    applyStimulus(1'b1, 1'b1, 16'd5, 1'b0);
    run_cycles(200, 1'b1);

    // Clamp: 0 and 1 both behave as 2.
    applyStimulus(1'b1, 1'b1, 16'd0, 1'b0);
    run_cycles(50, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'd1, 1'b0);
    run_cycles(50, 1'b1);

    // Resync mid-bit at phase 11.
    applyStimulus(1'b1, 1'b1, 16'd78, 1'b0);
    guard = 0;
    while (model_phase() != 11 && guard < 2000) begin
      run_cycles(1, 1'b1);
      guard++;
    end
    applyStimulus(1'b1, 1'b0, bif.i_div, 1'b1);
    run_cycles(OSR * 78 + 20, 1'b1);

    // Resync and load together: load applies.
    applyStimulus(1'b1, 1'b1, 16'd7, 1'b1);
    run_cycles(300, 1'b1);

    // Enable gap of 37 cycles at prescaler count 40.
    applyStimulus(1'b1, 1'b1, 16'd78, 1'b0);
    run_cycles(OSR * 78 / 2 + 5, 1'b1);
    guard = 0;
    while ((n % d) != 40 && guard < 200) begin
      run_cycles(1, 1'b1);
      guard++;
    end
    run_cycles(37, 1'b0);
    run_cycles(100, 1'b1);

    // Async reset while baud_clk is high, after loading divisor 5.
    applyStimulus(1'b1, 1'b1, 16'd5, 1'b0);
    guard = 0;
    while (m_bclk !== 1'b1 && guard < 3000) begin
      run_cycles(1, 1'b1);
      guard++;
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", zero);
    n      = 0;
    d      = DEF_DIV;
    m_bclk = 1'b0;
    run_cycles(3, 1'b1);
    rst_n = 1'b1;
    run_cycles(DEF_DIV * OSR + 100, 1'b1);

    // Randomised traffic: sporadic loads, resyncs, enable gaps, junk divisors.
    for (int i = 0; i < 20000; i++) begin
      logic             r_en;
      logic             r_load;
      logic             r_resync;
      logic [DIV_W-1:0] r_div;
      r_en     = ($urandom_range(0, 19) != 0);
      r_load   = ($urandom_range(0, 299) == 0);
      r_resync = ($urandom_range(0, 399) == 0);
      r_div    = r_load ? DIV_W'($urandom_range(0, 12)) : DIV_W'($urandom);
      applyStimulus(r_en, r_load, r_div, r_resync);
    end

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
